// File: rtl/ram_bus_slave_pkg.sv
// Shared encodings, record types and small helpers for the RAM bus slave.
package ram_bus_slave_pkg;

  // Access size encodings carried on cmd_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  // Depth of the response buffer behind the bypass stage
  localparam int RSP_DEPTH = 2;

  // Command attributes remembered for the cycle in which read data returns
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic [1:0] off;
    logic       err;
  } s1_t;

  // One buffered response
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Illegal size or an address not aligned to the access size
  function automatic logic cmd_is_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Right-align the addressed lanes of a RAM word and zero-extend by size
  function automatic logic [31:0] read_align(input logic [31:0] dout,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = dout >> {off, 3'b000};
    case (size)
      SZ_BYTE: r = {24'h0, sh[7:0]};
      SZ_HALF: r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_bus_slave_rsp_fifo2.sv
// Two-entry in-order response buffer; simultaneous push and pop keep the count.
module rsp_fifo2
  import ram_bus_slave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_t       push_data,
  input  logic       pop,
  output logic [1:0] count,
  output rsp_t       head
);

  localparam logic [1:0] FULL = 2'(RSP_DEPTH);

  rsp_t       mem_q [RSP_DEPTH];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  // Pointer and occupancy update; a push into a full buffer is only taken alongside a pop
  always_comb begin
    do_pop   = pop & (count_q != 2'd0);
    do_push  = push & ((count_q != FULL) | do_pop);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Control state, cleared asynchronously so buffered responses vanish on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_bus_slave.sv
// Bus slave in front of a single-port 32-bit RAM: one cycle minimum latency,
// a bypass stage for the returning read data and a 2-entry response buffer.
module ram_bus_slave
  import ram_bus_slave_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_addr,
  input  logic              cmd_we,
  input  logic [1:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  logic       s1_valid_q, s1_valid_d;
  s1_t        s1_q, s1_d;
  logic [1:0] fifo_count;
  rsp_t       fifo_head;
  rsp_t       s1_rsp;
  rsp_t       rsp_sel;
  logic       fifo_push, fifo_pop;
  logic [1:0] occupancy;
  logic [1:0] cmd_off;
  logic       cmd_err;
  logic       accept;
  logic       legal;

  // High address bits are deliberately dropped: the RAM aliases across the bus space
  logic unused_addr_hi;
  assign unused_addr_hi = ^cmd_addr[31:ADDR_W+2];

  // Acceptance and RAM request; ready depends only on registered occupancy
  always_comb begin
    occupancy  = {1'b0, s1_valid_q} + fifo_count;
    cmd_ready  = rst_n & (occupancy < 2'd2);
    cmd_off    = cmd_addr[1:0];
    cmd_err    = cmd_is_err(cmd_size, cmd_off);
    accept     = cmd_valid & cmd_ready;
    legal      = accept & ~cmd_err;
    ram_en     = legal;
    ram_we     = legal & cmd_we;
    ram_wem    = (legal && cmd_we) ? lane_mask(cmd_size, cmd_off) : 4'b0000;
    ram_addr   = cmd_addr[ADDR_W+1:2];
    ram_din    = cmd_wdata << {cmd_off, 3'b000};
    s1_valid_d = accept;
    s1_d       = s1_q;
    if (accept) begin
      s1_d.we   = cmd_we;
      s1_d.size = cmd_size;
      s1_d.off  = cmd_off;
      s1_d.err  = cmd_err;
    end
  end

  // Stage s1 holds the accepted command for the cycle its RAM data appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Response selection: buffered head first, else bypass of the s1 result
  always_comb begin
    s1_rsp.err   = s1_q.err;
    s1_rsp.rdata = (s1_q.we || s1_q.err) ? 32'h0 : read_align(ram_dout, s1_q.size, s1_q.off);
    rsp_valid    = s1_valid_q | (fifo_count != 2'd0);
    rsp_sel      = (fifo_count != 2'd0) ? fifo_head : s1_rsp;
    rsp_rdata    = rsp_valid ? rsp_sel.rdata : 32'h0;
    rsp_err      = rsp_valid & rsp_sel.err;
    fifo_pop     = rsp_ready & (fifo_count != 2'd0);
    // s1 is consumed directly only when nothing older is waiting ahead of it
    fifo_push    = s1_valid_q & ~(rsp_ready & (fifo_count == 2'd0));
  end

  rsp_fifo2 u_rsp_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (s1_rsp),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_ram_bus_slave.sv
// Directed bench for ram_bus_slave with a behavioural single-port RAM.
module tb_ram_bus_slave;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_addr;
  logic              cmd_we;
  logic [1:0]        cmd_size;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_wem;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_bus_slave #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_wem   (ram_wem),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Behavioural RAM: byte-masked write, registered read held until the next read
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    cmd_valid = v;
    cmd_we    = we;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drv(1'b1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFF);
    #1;
    total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++;
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_wem !== 4'b0000)
      $display("FAIL reset_ram got en=%b we=%b wem=%b exp 0 0 0000", ram_en, ram_we, ram_wem); else passed++;
    total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL reset_rsp got %h/%b exp 00000000/0", rsp_rdata, rsp_err); else passed++;
    tick(); tick();
    rst_n = 1'b1;
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", cmd_ready); else passed++;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_word_write_byte_read();
    drv(1'b1, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
    #1;
    total++; if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_wem !== 4'b1111)
      $display("FAIL ww_ctrl got en=%b we=%b wem=%b exp 1 1 1111", ram_en, ram_we, ram_wem); else passed++;
    total++; if (ram_addr !== 14'd4 || ram_din !== 32'hDEAD_BEEF)
      $display("FAIL ww_addr_din got %h/%h exp 0004/deadbeef", ram_addr, ram_din); else passed++;
    tick();
    drv(1'b1, 1'b0, 2'd0, 32'h11, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL ww_rsp got v=%b d=%h e=%b exp 1 00000000 0", rsp_valid, rsp_rdata, rsp_err); else passed++;
    total++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_wem !== 4'b0000 || ram_addr !== 14'd4)
      $display("FAIL br_ctrl got en=%b we=%b wem=%b a=%h exp 1 0 0000 0004", ram_en, ram_we, ram_wem, ram_addr); else passed++;
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00BE || rsp_err !== 1'b0)
      $display("FAIL br_rsp got v=%b d=%h e=%b exp 1 000000be 0", rsp_valid, rsp_rdata, rsp_err); else passed++;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL br_idle got %b exp 0", rsp_valid); else passed++;
    $display("test_word_write_byte_read done");
  endtask

  task automatic test_half_write();
    drv(1'b1, 1'b1, 2'd1, 32'h0E, 32'h0000_A5C3);
    #1;
    total++; if (ram_wem !== 4'b1100 || ram_din !== 32'hA5C3_0000 || ram_addr !== 14'd3)
      $display("FAIL hw_req got wem=%b din=%h a=%h exp 1100 a5c30000 0003", ram_wem, ram_din, ram_addr); else passed++;
    tick();
    drv(1'b1, 1'b0, 2'd1, 32'h0E, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL hw_rsp got v=%b d=%h e=%b exp 1 00000000 0", rsp_valid, rsp_rdata, rsp_err); else passed++;
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (rsp_rdata !== 32'h0000_A5C3 || rsp_err !== 1'b0)
      $display("FAIL hr_rsp got d=%h e=%b exp 0000a5c3 0", rsp_rdata, rsp_err); else passed++;
    tick();
    $display("test_half_write done");
  endtask

  task automatic test_errors();
    drv(1'b1, 1'b0, 2'd2, 32'h06, 32'h0);
    #1;
    total++; if (cmd_ready !== 1'b1 || ram_en !== 1'b0)
      $display("FAIL mis_req got rdy=%b en=%b exp 1 0", cmd_ready, ram_en); else passed++;
    tick();
    drv(1'b1, 1'b1, 2'd3, 32'h20, 32'h1234_5678);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL mis_rsp got v=%b e=%b d=%h exp 1 1 00000000", rsp_valid, rsp_err, rsp_rdata); else passed++;
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0)
      $display("FAIL ill_req got en=%b we=%b exp 0 0", ram_en, ram_we); else passed++;
    tick();
    // Address bit 16 lies above the RAM and must alias without error
    drv(1'b1, 1'b1, 2'd2, 32'h0001_0020, 32'h1234_5678);
    #1;
    total++; if (rsp_err !== 1'b1) $display("FAIL ill_rsp got e=%b exp 1", rsp_err); else passed++;
    total++; if (ram_en !== 1'b1 || ram_addr !== 14'd8)
      $display("FAIL alias_req got en=%b a=%h exp 1 0008", ram_en, ram_addr); else passed++;
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0)
      $display("FAIL alias_rsp got v=%b e=%b exp 1 0", rsp_valid, rsp_err); else passed++;
    tick();
    $display("test_errors done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 2'd2, 32'h40 + 32'(4*i), 32'hC0DE_0000 | 32'(i));
      tick();
    end
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 2'd2, 32'h40 + 32'(4*i), 32'h0);
      #1;
      total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, cmd_ready); else passed++;
      if (i > 0) begin
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== (32'hC0DE_0000 | 32'(i-1)))
          $display("FAIL b2b_rsp%0d got v=%b d=%h exp 1 %h", i-1, rsp_valid, rsp_rdata, 32'hC0DE_0000 | 32'(i-1)); else passed++;
      end
      tick();
    end
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE_0003)
      $display("FAIL b2b_rsp3 got v=%b d=%h exp 1 c0de0003", rsp_valid, rsp_rdata); else passed++;
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drv(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL bp_c0_ready got %b exp 1", cmd_ready); else passed++;
    tick();
    drv(1'b1, 1'b0, 2'd2, 32'h44, 32'h0);
    #1;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE_0000)
      $display("FAIL bp_c1 got rdy=%b v=%b d=%h exp 1 1 c0de0000", cmd_ready, rsp_valid, rsp_rdata); else passed++;
    tick();
    drv(1'b1, 1'b0, 2'd2, 32'h48, 32'h0);
    #1;
    total++; if (cmd_ready !== 1'b0 || rsp_rdata !== 32'hC0DE_0000)
      $display("FAIL bp_c2 got rdy=%b d=%h exp 0 c0de0000", cmd_ready, rsp_rdata); else passed++;
    tick();
    #1;
    total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE_0000 || rsp_err !== 1'b0)
      $display("FAIL bp_hold got rdy=%b v=%b d=%h e=%b exp 0 1 c0de0000 0", cmd_ready, rsp_valid, rsp_rdata, rsp_err); else passed++;
    tick();
    rsp_ready = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0 || rsp_rdata !== 32'hC0DE_0000)
      $display("FAIL bp_drain0 got rdy=%b d=%h exp 0 c0de0000", cmd_ready, rsp_rdata); else passed++;
    tick();
    #1;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE_0001)
      $display("FAIL bp_drain1 got rdy=%b v=%b d=%h exp 1 1 c0de0001", cmd_ready, rsp_valid, rsp_rdata); else passed++;
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE_0002)
      $display("FAIL bp_third got v=%b d=%h exp 1 c0de0002", rsp_valid, rsp_rdata); else passed++;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL bp_idle got %b exp 0", rsp_valid); else passed++;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 1'b1, 2'd2, 32'h80, 32'h55AA_55AA);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    rsp_ready = 1'b0;
    drv(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
    tick();
    drv(1'b1, 1'b0, 2'd2, 32'h44, 32'h0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1)
      $display("FAIL rm_full got rdy=%b v=%b exp 0 1", cmd_ready, rsp_valid); else passed++;
    drv(1'b1, 1'b0, 2'd2, 32'h4C, 32'h0);
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0 || ram_en !== 1'b0)
      $display("FAIL rm_assert got v=%b d=%h rdy=%b en=%b exp 0 00000000 0 0", rsp_valid, rsp_rdata, cmd_ready, ram_en); else passed++;
    tick(); tick();
    rsp_ready = 1'b1;
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL rm_release got rdy=%b v=%b exp 1 0", cmd_ready, rsp_valid); else passed++;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL rm_stale got %b exp 0", rsp_valid); else passed++;
    drv(1'b1, 1'b0, 2'd2, 32'h80, 32'h0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55AA_55AA)
      $display("FAIL rm_committed got v=%b d=%h exp 1 55aa55aa", rsp_valid, rsp_rdata); else passed++;
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_word_write_byte_read();
    test_half_write();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_bus_slave.md
RAM_BUS_SLAVE -- requirements
Module: ram_bus_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning RAM word-address width (RAM depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have ports, in order:
 clk  in  1  sole clock, rising edge.
 rst_n  in  1  asynchronous active-low reset.
 cmd_valid  in  1  command present.
 cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
 cmd_addr  in  32  byte address.
 cmd_we  in  1  1=write, 0=read.
 cmd_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
 cmd_wdata  in  32  write data, right-aligned (lane 0 upward).
 rsp_valid  out  1  response present.
 rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
 rsp_rdata  out  32  read data, right-aligned, zero-extended; 0 for writes and errors.
 rsp_err  out  1  misaligned or illegal-size command.
 ram_en  out  1  RAM port enable.
 ram_we  out  1  RAM write.
 ram_wem  out  4  RAM byte-lane mask.
 ram_addr  out  ADDR_W  RAM word address.
 ram_din  out  32  RAM write data, lane-shifted.
 ram_dout  in  32  RAM read data, valid the cycle after a read enable, held until the next read.

Function
REQ-003 SHALL compute cmd_ready = (occupancy < 2), with occupancy = s1_valid + fifo_count; cmd_ready SHALL have no combinational path from rsp_ready.
REQ-004 SHALL flag an accepted command as error if cmd_size=3, cmd_size=1 with addr[0]=1, or cmd_size=2 with addr[1:0]!=0.
REQ-005 SHALL, in the acceptance cycle of a legal command only, drive ram_en=1, ram_we=cmd_we, ram_addr=cmd_addr[ADDR_W+1:2], and ram_din=cmd_wdata shifted left by 8*addr[1:0].
REQ-006 SHALL set ram_wem to 0001<<off for byte, 0011<<off for half, and 1111 for word, where off = addr[1:0]; ram_wem SHALL be 0000 for reads.
REQ-007 SHALL ignore cmd_addr bits above ADDR_W+1, so addresses alias with no error.
REQ-008 SHALL drive ram_en=0 whenever no legal command is accepted, including error commands.
REQ-009 SHALL capture {we, size, off, err} into stage s1 on every accepted command; s1_valid SHALL be set for exactly one cycle per command unless the entry is pushed on.
REQ-010 SHALL set rsp_valid = s1_valid OR fifo_count>0.
REQ-011 SHALL present the FIFO head when the FIFO is non-empty, else the s1 result formed from ram_dout (bypass).
REQ-012 SHALL form the read result as ram_dout>>(8*off), masked to 8/16/32 bits by size.
REQ-013 SHALL push the s1 result into a 2-entry FIFO in the cycle after acceptance if that result is not consumed in that cycle.
REQ-014 SHALL give minimum latency of 1 cycle (accept at N, rsp_valid at N+1) and sustain throughput of 1 command per cycle while rsp_ready=1.
REQ-015 SHALL return responses strictly in command order.
REQ-016 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-017 SHALL, when a FIFO pop and an s1 push occur in the same cycle, keep fifo_count unchanged and preserve order.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously clear s1_valid and fifo_count, and force cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_en=0, ram_we=0, ram_wem=0.
REQ-019 SHALL drop any in-flight or buffered response when reset is asserted mid-operation; a RAM write issued on a clock edge before reset SHALL remain committed.
REQ-020 SHALL assert cmd_ready on the first clk edge after rst_n deasserts.

Structure
REQ-021 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and RSP_DEPTH=2 in the shared core package.
REQ-022 SHALL implement the response buffer as sub-module rsp_fifo2: 2 entries of {rdata[31:0], err}, with push, pop, count, and head outputs.

Verification
REQ-023 Word write 0xDEADBEEF @0x10, then byte read @0x11 -> ram_wem=1111, ram_addr=4; read response rdata=0x000000BE, err=0, at N+1.
REQ-024 Half write 0xA5C3 @0x0E -> ram_wem=1100, ram_din=0xA5C30000; response rdata=0, err=0.
REQ-025 Word read @0x06 -> ram_en stays 0; response err=1, rdata=0.
REQ-026 Four back-to-back reads with rsp_ready=1 -> four responses on consecutive cycles N+1..N+4, in order.
REQ-027 rsp_ready=0 during 3 reads -> only 2 accepted, cmd_ready=0 thereafter; releasing rsp_ready drains both in order, then the third is accepted.
REQ-028 rst_n low while fifo_count=2 -> rsp_valid=0 immediately; after release, cmd_ready=1 with no stale responses.
